// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared state, opcode, funct and ALU encodings for the MIPS control.
// Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_en gates ALUCONTROL to zero in states that do not use the ALU.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       branch;
        logic       pcwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       alu_en;
    } ctrl_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; c.alu_en = 1'b1; end
            S_DECODE:   begin c.alusrcb = 2'b11; c.alu_en = 1'b1; end
            S_MEMADR,
            S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_en = 1'b1; end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; c.alu_en = 1'b1; end
            S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_BRANCH:   begin c.alusrca = 1'b1; c.branch = 1'b1; c.pcsrc = 2'b01;
                              c.aluop = ALUOP_SUB; c.alu_en = 1'b1; end
            S_JUMP:     begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps ALUOP and the R-type funct field onto the 3-bit ALU control.
// Revision : 1.0
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] FUNCT,
    input  logic [1:0] ALUOP,
    output logic [2:0] ALUCONTROL
);

    always_comb begin
        ALUCONTROL = ALU_ADD;
        case (ALUOP)
            ALUOP_ADD: ALUCONTROL = ALU_ADD;
            ALUOP_SUB: ALUCONTROL = ALU_SUB;
            default: begin
                case (FUNCT)
                    FN_ADD:  ALUCONTROL = ALU_ADD;
                    FN_SUB:  ALUCONTROL = ALU_SUB;
                    FN_AND:  ALUCONTROL = ALU_AND;
                    FN_OR:   ALUCONTROL = ALU_OR;
                    FN_SLT:  ALUCONTROL = ALU_SLT;
                    default: ALUCONTROL = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM sequencing the multicycle MIPS datapath control lines.
// Revision : 1.0
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [5:0]         OP,
    input  logic [5:0]         FUNCT,
    output logic               IORD,
    output logic               MEMWRITE,
    output logic               IRWRITE,
    output logic               REGDST,
    output logic               MEMTOREG,
    output logic               REGWRITE,
    output logic               ALUSRCA,
    output logic               BRANCH,
    output logic               PCWRITE,
    output logic [1:0]         ALUSRCB,
    output logic [1:0]         PCSRC,
    output logic [2:0]         ALUCONTROL,
    output logic               ILLEGAL,
    output logic [STATE_W-1:0] STATE
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic       illegal_q, illegal_d;
    logic       is_sw_q, is_sw_d;
    logic [2:0] w_alucontrol;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        is_sw_d   = is_sw_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // lw/sw share MEMADR, so the direction is captured here.
                is_sw_d = (OP == OP_SW);
                case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_supported(FUNCT)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEXEC;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            illegal_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= state_ctrl(state_d);
            illegal_q <= illegal_d;
            is_sw_q   <= is_sw_d;
        end
    end

    alu_decoder u_alu_decoder (
        .FUNCT      (FUNCT),
        .ALUOP      (ctrl_q.aluop),
        .ALUCONTROL (w_alucontrol)
    );

    // Registered FETCH controls are held during reset but masked until release.
    assign IORD       = ctrl_q.iord     & ~RESET;
    assign MEMWRITE   = ctrl_q.memwrite & ~RESET;
    assign IRWRITE    = ctrl_q.irwrite  & ~RESET;
    assign REGDST     = ctrl_q.regdst   & ~RESET;
    assign MEMTOREG   = ctrl_q.memtoreg & ~RESET;
    assign REGWRITE   = ctrl_q.regwrite & ~RESET;
    assign ALUSRCA    = ctrl_q.alusrca  & ~RESET;
    assign BRANCH     = ctrl_q.branch   & ~RESET;
    assign PCWRITE    = ctrl_q.pcwrite  & ~RESET;
    assign ALUSRCB    = RESET ? 2'b00 : ctrl_q.alusrcb;
    assign PCSRC      = RESET ? 2'b00 : ctrl_q.pcsrc;
    assign ALUCONTROL = (RESET || !ctrl_q.alu_en) ? 3'b000 : w_alucontrol;
    assign ILLEGAL    = illegal_q & ~RESET;
    assign STATE      = RESET ? STATE_W'(S_FETCH) : STATE_W'(state_q);

endmodule
`default_nettype wire
